horner_pipe: RTL and testbench
==============================

# horner_pipe

Parametrised, fully pipelined fixed-point polynomial evaluator, y = Σ c[k]·x^k for k = 0..ORDER, computed by Horner's rule.
- Successor to the fixed 5th-order exp(x) Taylor datapath, which it generalises in four ways: polynomial order, operand widths and fractional points, runtime-loadable coefficients, and a true valid/ready handshake with lossless backpressure.
- Sits between a streaming sample source and sink in the lab datapath.

## Interface
Parameters:
- WIDTHIN, 16, width of x and coefficients (unsigned, FRAC_IN fractional bits; default Q2.14)
- WIDTHOUT, 32, accumulator/output width (unsigned, FRAC_OUT fractional bits; default Q7.25)
- FRAC_IN, 14, fractional bits of x and coefficients
- FRAC_OUT, 25, fractional bits of accumulator and y; must satisfy FRAC_OUT ≥ FRAC_IN
- ORDER, 5, polynomial order N (≥ 1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- i_valid  in  1  input sample valid
- o_ready  out  1  block accepts a sample this cycle
- i_x  in  WIDTHIN  sample x
- o_valid  out  1  o_y holds a result
- i_ready  in  1  sink accepts o_y this cycle
- o_y  out  WIDTHOUT  result
- coef_we  in  1  coefficient write request
- coef_ready  out  1  coefficient write accepted this cycle
- coef_addr  in  $clog2(ORDER+1)  coefficient index k
- coef_data  in  WIDTHIN  value of c[k]

## Operation
- Coefficient file c[0..ORDER]: reset loads the exp Taylor values 1/k! (Q2.14 default: 0x4000, 0x4000, 0x2000, 0x0AAA, 0x02AA, 0x0088 for k = 0..5; higher k = 0).
- Coefficient write occurs when coef_we & coef_ready. coef_ready = 1 only when no stage holds a valid sample and i_valid = 0. In-flight samples therefore always see one consistent coefficient set.
- Writes to coef_addr > ORDER are accepted and ignored.
- Alignment: align(c) = zero-extend(c) << (FRAC_OUT − FRAC_IN), truncated to WIDTHOUT.
- Horner recurrence:
  - acc0 = align(c[N])
  - for step k = 1..N: acc_k = trunc(acc_{k−1} · x >> FRAC_IN) + align(c[N−k])
  - trunc keeps the low WIDTHOUT bits.
- All arithmetic is unsigned and modulo 2^WIDTHOUT; overflow wraps silently. Products use the full WIDTHOUT+WIDTHIN width before shifting.
- x travels with its sample through every stage.
- Global advance: en = ~o_valid | i_ready. When en = 1, every stage register, its valid bit and its x copy load from the previous stage. When en = 0, everything holds.
- o_ready = en; a sample is accepted on i_valid & o_ready.
- Bubbles propagate as valid = 0 and are not collapsed.

## Timing
- Stage layout: input register (x, valid) → per step k, a multiply register then an add register → output register. The output register drives o_y/o_valid directly.
- Latency: 2·ORDER + 2 cycles from the accepting edge to o_valid = 1 (12 for ORDER = 5), absent stalls.
- Throughput: 1 sample/cycle while i_ready = 1.
- Backpressure: with o_valid = 1 and i_ready = 0, o_y, o_valid and all stages hold. No sample is lost or duplicated, and order is preserved. A result transfers on o_valid & i_ready.
- o_valid does not depend combinationally on i_ready.
- Reset values: o_valid = 0, o_y = 0, all stage valids and data = 0, coefficients = defaults. After reset deasserts, o_ready = 1 and coef_ready = 1.
- Reset mid-operation discards all in-flight samples; no o_valid appears until new samples have been accepted and have traversed the full latency.
- Simultaneous coef_we and i_valid: the sample is accepted and the write is held off (coef_ready = 0).
- coef_ready rises the cycle after the last valid sample leaves the output register.

## Structure
- Package horner_pkg holds:
  - the default coefficient function (1/k! rounded down to FRAC_IN bits)
  - latency function LAT(ORDER) = 2·ORDER + 2
  - the align() function
- Sub-module horner_step contains:
  - one multiply register and one add register with their valid bits and x copy
  - enable en, and coefficient input align(c[N−k])
- The top instantiates ORDER horner_step modules in a generate loop and adds the input/output registers and the coefficient file.

## Test plan
- Default coefficients, ORDER = 5, i_x = 0x0000, i_ready = 1 → exactly 12 cycles later o_valid = 1, o_y = 0x02000000.
- Write c[1] = 0x4000 and all other c[k] = 0; stream x = 0x4000, 0x2000, 0x0001 → o_y = 0x02000000, 0x01000000, 0x00000800 on consecutive cycles.
- Stream 20 random x with i_ready toggled randomly → outputs match a bit-accurate reference model in order, with no drops or duplicates, and o_y stable while o_valid & ~i_ready.
- coef_we asserted while 3 samples are in flight → coef_ready = 0 until the pipeline drains. Results use the old coefficients; the first sample after the write uses the new ones.
- Assert reset for 1 cycle mid-stream → o_valid = 0 and o_y = 0 immediately. No stale results appear, and coefficients return to their defaults.
- ORDER = 2, WIDTHIN = 12, FRAC_IN = 10, WIDTHOUT = 24, FRAC_OUT = 20 → latency 6 and a wrap-around case matching modulo-2^24 model results.

Source files
------------

// File: rtl/horner_pkg.sv
// rtl/horner_pkg.sv - shared helpers for the Horner polynomial pipeline
package horner_pkg;

  function automatic int lat(int order);
    return 2 * order + 2;
  endfunction

  // Reset contents of the coefficient file: exp(x) Taylor terms, zero beyond k = 5
  function automatic logic [63:0] default_coef(int k, int frac_in);
    logic [63:0] fact;
    fact = 64'd1;
    if (k > 5) return 64'd0;
    for (int i = 2; i <= k; i++) fact = fact * 64'(i);
    return (64'd1 << frac_in) / fact;
  endfunction

  function automatic logic [127:0] align(logic [63:0] c, int shift);
    return {64'd0, c} << shift;
  endfunction

endpackage

// File: rtl/horner_step.sv
// rtl/horner_step.sv - one Horner step: multiply register followed by add register
module horner_step
  import horner_pkg::*;
#(
  parameter int WIDTHIN  = 16,
  parameter int WIDTHOUT = 32,
  parameter int FRAC_IN  = 14
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_en,
  input  logic                i_valid,
  input  logic [WIDTHIN-1:0]  i_x,
  input  logic [WIDTHOUT-1:0] i_acc,
  input  logic [WIDTHOUT-1:0] i_coef,
  output logic                o_valid,
  output logic [WIDTHIN-1:0]  o_x,
  output logic [WIDTHOUT-1:0] o_acc,
  output logic                o_busy
);

  localparam int PW = WIDTHOUT + WIDTHIN;

  logic [PW-1:0]       w_prod;
  logic                r_mul_valid;
  logic [WIDTHIN-1:0]  r_mul_x;
  logic [WIDTHOUT-1:0] r_mul;
  logic                r_add_valid;
  logic [WIDTHIN-1:0]  r_add_x;
  logic [WIDTHOUT-1:0] r_add;

  assign w_prod = PW'(i_acc) * PW'(i_x);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mul_valid <= 1'b0;
      r_mul_x     <= '0;
      r_mul       <= '0;
      r_add_valid <= 1'b0;
      r_add_x     <= '0;
      r_add       <= '0;
    end else if (i_en) begin
      r_mul_valid <= i_valid;
      r_mul_x     <= i_x;
      r_mul       <= WIDTHOUT'(w_prod >> FRAC_IN);
      r_add_valid <= r_mul_valid;
      r_add_x     <= r_mul_x;
      r_add       <= r_mul + i_coef;
    end
  end

  assign o_valid = r_add_valid;
  assign o_x     = r_add_x;
  assign o_acc   = r_add;
  assign o_busy  = r_mul_valid | r_add_valid;

endmodule

// File: rtl/horner_pipe.sv
// rtl/horner_pipe.sv - pipelined fixed-point polynomial evaluator with loadable coefficients
module horner_pipe
  import horner_pkg::*;
#(
  parameter int WIDTHIN  = 16,
  parameter int WIDTHOUT = 32,
  parameter int FRAC_IN  = 14,
  parameter int FRAC_OUT = 25,
  parameter int ORDER    = 5
)(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [WIDTHIN-1:0]           i_x,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [WIDTHOUT-1:0]          o_y,
  input  logic                         coef_we,
  output logic                         coef_ready,
  input  logic [$clog2(ORDER+1)-1:0]   coef_addr,
  input  logic [WIDTHIN-1:0]           coef_data
);

  logic                w_en;
  logic                r_in_valid;
  logic [WIDTHIN-1:0]  r_in_x;
  logic                r_out_valid;
  logic [WIDTHOUT-1:0] r_out_y;
  logic [WIDTHIN-1:0]  r_coef    [0:ORDER];
  logic [WIDTHOUT-1:0] w_coef_al [0:ORDER];
  logic                w_valid   [0:ORDER];
  logic [WIDTHIN-1:0]  w_x       [0:ORDER];
  logic [WIDTHOUT-1:0] w_acc     [0:ORDER];
  logic [ORDER-1:0]    w_busy;

  assign w_en    = ~r_out_valid | i_ready;
  assign o_ready = w_en;
  assign o_valid = r_out_valid;
  assign o_y     = r_out_y;

  // Writes wait for an empty pipe so every in-flight sample sees one coefficient set
  assign coef_ready = ~(r_in_valid | (|w_busy) | r_out_valid | i_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= ORDER; k++) r_coef[k] <= WIDTHIN'(default_coef(k, FRAC_IN));
    end else if (coef_we && coef_ready && (int'(coef_addr) <= ORDER)) begin
      r_coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_valid  <= 1'b0;
      r_in_x      <= '0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
    end else if (w_en) begin
      r_in_valid  <= i_valid;
      r_in_x      <= i_x;
      r_out_valid <= w_valid[ORDER];
      r_out_y     <= w_acc[ORDER];
    end
  end

  for (genvar k = 0; k <= ORDER; k++) begin : g_align
    assign w_coef_al[k] = WIDTHOUT'(align(64'(r_coef[k]), FRAC_OUT - FRAC_IN));
  end

  assign w_valid[0] = r_in_valid;
  assign w_x[0]     = r_in_x;
  assign w_acc[0]   = w_coef_al[ORDER];

  for (genvar j = 0; j < ORDER; j++) begin : g_step
    horner_step #(
      .WIDTHIN  (WIDTHIN),
      .WIDTHOUT (WIDTHOUT),
      .FRAC_IN  (FRAC_IN)
    ) u_step (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_en),
      .i_valid (w_valid[j]),
      .i_x     (w_x[j]),
      .i_acc   (w_acc[j]),
      .i_coef  (w_coef_al[ORDER-1-j]),
      .o_valid (w_valid[j+1]),
      .o_x     (w_x[j+1]),
      .o_acc   (w_acc[j+1]),
      .o_busy  (w_busy[j])
    );
  end

endmodule

// File: tb/tb_horner_pipe.sv
// tb/tb_horner_pipe.sv - randomized scoreboard bench for horner_pipe
module tb_horner_pipe;
  import horner_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, o_ready, o_valid, i_ready, coef_we, coef_ready;
  logic [15:0] i_x, coef_data;
  logic [31:0] o_y;
  logic [2:0]  coef_addr;

  logic        i2_valid, o2_ready, o2_valid, i2_ready, coef2_we, coef2_ready;
  logic [11:0] i2_x, coef2_data;
  logic [23:0] o2_y;
  logic [1:0]  coef2_addr;

  int              n_cmp = 0;
  int              n_fail = 0;
  logic [31:0]     exp_q[$];
  longint unsigned c1[0:7];
  longint unsigned c2[0:7];
  bit              rand_ready = 1'b0;

  always #5 clk = ~clk;

  horner_pipe u_dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready), .i_x(i_x),
    .o_valid(o_valid), .i_ready(i_ready), .o_y(o_y), .coef_we(coef_we),
    .coef_ready(coef_ready), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  horner_pipe #(.WIDTHIN(12), .WIDTHOUT(24), .FRAC_IN(10), .FRAC_OUT(20), .ORDER(2)) u_dut2 (
    .clk(clk), .reset(reset), .i_valid(i2_valid), .o_ready(o2_ready), .i_x(i2_x),
    .o_valid(o2_valid), .i_ready(i2_ready), .o_y(o2_y), .coef_we(coef2_we),
    .coef_ready(coef2_ready), .coef_addr(coef2_addr), .coef_data(coef2_data)
  );

  // Reference: y = sum c[k] x^k evaluated by Horner's rule, modulo 2^wout
  function automatic longint unsigned model(longint unsigned x, longint unsigned c[0:7],
                                            int n, int wout, int fin, int fout);
    longint unsigned mask, acc, term;
    mask = (64'd1 << wout) - 64'd1;
    acc  = (c[n] << (fout - fin)) & mask;
    for (int k = 1; k <= n; k++) begin
      term = (c[n-k] << (fout - fin)) & mask;
      acc  = ((((acc * x) >> fin) & mask) + term) & mask;
    end
    return acc;
  endfunction

  function automatic longint unsigned taylor(int k, int fin);
    longint unsigned f;
    f = 1;
    for (int i = 2; i <= k; i++) f = f * longint'(i);
    return (k > 5) ? 64'd0 : ((64'd1 << fin) / f);
  endfunction

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_defaults();
    for (int k = 0; k < 8; k++) begin
      c1[k] = (k <= 5) ? taylor(k, 14) : 64'd0;
      c2[k] = (k <= 2) ? taylor(k, 10) : 64'd0;
    end
  endtask

  task automatic send(logic [15:0] x);
    bit ok = 1'b0;
    i_valid = 1'b1;
    i_x     = x;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = o_ready;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    if (ok) exp_q.push_back(32'(model(64'(x), c1, 5, 32, 14, 25)));
    else chk("send_timeout", 0, 1);
  endtask

  task automatic write_coef(logic [2:0] addr, logic [15:0] data);
    bit ok = 1'b0;
    coef_we = 1'b1; coef_addr = addr; coef_data = data;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = coef_ready;
      @(posedge clk); #1;
    end
    coef_we = 1'b0;
    if (!ok) chk("coef_timeout", 0, 1);
    else if (addr <= 3'd5) c1[addr] = 64'(data);
  endtask

  task automatic drain();
    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(posedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic send2_check(logic [11:0] x);
    int cnt;
    bit ok = 1'b0;
    i2_valid = 1'b1; i2_x = x;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = o2_ready;
      @(posedge clk); #1;
    end
    i2_valid = 1'b0;
    cnt = 1;
    while (!o2_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency2", cnt, lat(2));
    chk("y2", o2_y, model(64'(x), c2, 2, 24, 10, 20));
    @(posedge clk); #1;
  endtask

  // i_ready driver: random while enabled, else held high
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pop on transfer, demand a frozen output while stalled
  initial begin
    logic [31:0] held;
    bit          have;
    have = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        have = 1'b0;
      end else if (o_valid) begin
        if (have) chk("stall_hold", o_y, held);
        if (i_ready) begin
          have = 1'b0;
          if (exp_q.size() == 0) chk("unexpected_result", o_y, 0);
          else chk("result", o_y, exp_q.pop_front());
        end else begin
          held = o_y;
          have = 1'b1;
        end
      end else if (have) begin
        chk("stall_valid_drop", 0, 1);
        have = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    reset = 1'b1;
    i_valid = 0; i_x = 0; coef_we = 0; coef_addr = 0; coef_data = 0;
    i2_valid = 0; i2_x = 0; i2_ready = 1; coef2_we = 0; coef2_addr = 0; coef2_data = 0;
    load_defaults();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_o_valid", o_valid, 0);
    chk("reset_o_y", o_y, 0);
    chk("reset_o_ready", o_ready, 1);
    chk("reset_coef_ready", coef_ready, 1);
    @(posedge clk); #1;

    // Latency with default coefficients, x = 0
    send(16'h0000);
    cnt = 1;
    while (!o_valid && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, lat(5));
    chk("y_x0_default", o_y, 32'h0200_0000);
    drain();

    // c[1] only; out-of-range addresses must be ignored
    for (int k = 0; k <= 5; k++) write_coef(3'(k), (k == 1) ? 16'h4000 : 16'h0000);
    write_coef(3'd6, 16'hFFFF);
    write_coef(3'd7, 16'h1234);
    send(16'h4000);
    send(16'h2000);
    send(16'h0001);
    drain();

    // Random coefficients, random x, random gaps and backpressure
    for (int k = 0; k <= 5; k++) write_coef(3'(k), 16'($urandom));
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(16'($urandom));
    end
    drain();
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Write requested while samples are in flight
    coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'h1357;
    send(16'($urandom));
    send(16'($urandom));
    send(16'($urandom));
    @(negedge clk);
    chk("coef_ready_in_flight", coef_ready, 0);
    cnt = 0;
    while (!coef_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    @(posedge clk); #1;
    coef_we = 1'b0;
    c1[0] = 64'h1357;
    chk("drained_before_write", exp_q.size(), 0);
    send(16'($urandom));
    drain();

    // Reset mid-stream while results are flowing
    for (int i = 0; i < 14; i++) send(16'($urandom));
    chk("flowing_before_reset", o_valid, 1);
    reset = 1'b1;
    #1;
    chk("midreset_o_valid", o_valid, 0);
    chk("midreset_o_y", o_y, 0);
    exp_q.delete();
    load_defaults();
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("postreset_o_ready", o_ready, 1);
    chk("postreset_coef_ready", coef_ready, 1);
    repeat (20) @(posedge clk);
    #1;
    send(16'($urandom));
    send(16'h4000);
    drain();

    // Narrow configuration: defaults, then all-ones coefficients to force wrap
    send2_check(12'h000);
    send2_check(12'($urandom));
    for (int k = 0; k <= 2; k++) begin
      coef2_we = 1'b1; coef2_addr = 2'(k); coef2_data = 12'hFFF;
      @(posedge clk); #1;
      c2[k] = 64'hFFF;
    end
    coef2_we = 1'b0;
    send2_check(12'hFFF);
    send2_check(12'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
